// File: rtl/pipo_pkg.sv
// Shared defaults and types for the pipo_async holding register.
package pipo_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;
   localparam logic [WIDTH_DEFAULT-1:0] RST_VAL_DEFAULT = '0;

   typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/pipo_cell.sv
// One bit of the holding register: enabled D flop with asynchronous active-high reset.
// The reset value arrives as an input so the top can fan out a per-bit constant.
module pipo_cell (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic e,
   input  logic rst_val,
   output logic q
);

   logic q_q;
   logic q_d;

   // Next state: capture d when enabled, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (e) begin
         q_d = d;
      end
   end

   // State register; reset wins over any load on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= rst_val;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/pipo_async.sv
// Parallel-in/parallel-out holding register with load enable and async active-high reset.
// q_valid reports that at least one load happened since reset; load_p pulses for one cycle
// after a load that changed the stored word.
// Optional macro PIPO_TRANSPARENT_EN: q shows d combinationally while e is high.
module pipo_async
   import pipo_pkg::*;
#(
   parameter int unsigned      WIDTH   = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEFAULT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             e,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             load_p
);

   logic [WIDTH-1:0] q_reg;
   logic             q_valid_q;
   logic             q_valid_d;
   logic             load_p_q;
   logic             load_p_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      pipo_cell u_cell (
         .clk     (clk),
         .rst     (rst),
         .d       (d[i]),
         .e       (e),
         .rst_val (RST_VAL[i]),
         .q       (q_reg[i])
      );
   end

   // Status next state: valid is sticky after any load; pulse only when the word changes.
   always_comb begin
      q_valid_d = q_valid_q;
      load_p_d  = 1'b0;
      if (e) begin
         q_valid_d = 1'b1;
         load_p_d  = (d != q_reg);
      end
   end

   // Status flops share the data path's async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid_q <= 1'b0;
         load_p_q  <= 1'b0;
      end else begin
         q_valid_q <= q_valid_d;
         load_p_q  <= load_p_d;
      end
   end

   // Output view: registered word, or a bypass of d while enabled when transparent.
   always_comb begin
      q = q_reg;
`ifdef PIPO_TRANSPARENT_EN
      if (rst) begin
         q = RST_VAL;
      end else if (e) begin
         q = d;
      end
`endif
   end

   assign q_valid = q_valid_q;
   assign load_p  = load_p_q;

endmodule

// File: tb/tb_pipo_async.sv
// Self-checking bench for pipo_async (WIDTH=4, RST_VAL=0) with a word-level reference model.
module tb_pipo_async;

   localparam int unsigned W = 4;
   localparam logic [W-1:0] RV = '0;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] d   = '0;
   logic         e   = 1'b0;
   logic [W-1:0] q;
   logic         q_valid;
   logic         load_p;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [W-1:0] exp_q     = RV;
   logic         exp_valid = 1'b0;
   logic         exp_lp    = 1'b0;

   pipo_async #(
      .WIDTH   (W),
      .RST_VAL (RV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .d       (d),
      .e       (e),
      .q       (q),
      .q_valid (q_valid),
      .load_p  (load_p)
   );

   always #5 clk = ~clk;

   // Expected visible q given the model state and current inputs.
   function automatic logic [W-1:0] view();
`ifdef PIPO_TRANSPARENT_EN
      if (rst) return RV;
      return e ? d : exp_q;
`else
      return exp_q;
`endif
   endfunction

   // One rising edge applied to the model, then return at the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         exp_q = RV; exp_valid = 1'b0; exp_lp = 1'b0;
      end else if (e) begin
         exp_lp = (d != exp_q); exp_q = d; exp_valid = 1'b1;
      end else begin
         exp_lp = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      rst = 1'b1; d = 4'hA; e = 1'b1;
      exp_q = RV; exp_valid = 1'b0; exp_lp = 1'b0;
      #1;
      total++;
      if (q !== RV || q_valid !== 1'b0 || load_p !== 1'b0) begin
         bad++;
         $display("FAIL reset_async q=%h v=%b lp=%b want q=%h v=0 lp=0", q, q_valid, load_p, RV);
      end
      // Edges with rst high and e=1 must not load.
      for (int i = 0; i < 2; i++) begin
         cycle();
         total++;
         if (q !== RV || q_valid !== 1'b0 || load_p !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold q=%h v=%b lp=%b want q=%h v=0 lp=0", q, q_valid, load_p, RV);
         end
      end
      rst = 1'b0; e = 1'b0;
   endtask

   task automatic test_hold();
      for (int i = 1; i < 16; i++) begin
         d = 4'(i);
         cycle();
         total++;
         if (q !== 4'h0 || q_valid !== 1'b0 || load_p !== 1'b0) begin
            bad++;
            $display("FAIL hold q=%h v=%b lp=%b want q=0 v=0 lp=0", q, q_valid, load_p);
         end
      end
   endtask

   task automatic test_load();
      e = 1'b1; d = 4'hF;
      cycle();
      total++;
      if (q !== view() || q_valid !== 1'b1 || load_p !== 1'b1) begin
         bad++;
         $display("FAIL load q=%h v=%b lp=%b want q=%h v=1 lp=1", q, q_valid, load_p, view());
      end
      e = 1'b0;
      cycle();
      total++;
      if (q !== 4'hF || q_valid !== 1'b1 || load_p !== 1'b0) begin
         bad++;
         $display("FAIL load_pulse_end q=%h v=%b lp=%b want q=f v=1 lp=0", q, q_valid, load_p);
      end
   endtask

   task automatic test_reload();
      e = 1'b1; d = 4'h3;
      cycle();
      total++;
      if (q !== 4'h3 || load_p !== 1'b1) begin
         bad++;
         $display("FAIL change q=%h lp=%b want q=3 lp=1", q, load_p);
      end
      cycle();
      total++;
      if (q !== 4'h3 || q_valid !== 1'b1 || load_p !== 1'b0) begin
         bad++;
         $display("FAIL same_value q=%h v=%b lp=%b want q=3 v=1 lp=0", q, q_valid, load_p);
      end
      e = 1'b0;
      cycle();
   endtask

   task automatic test_reset_mid();
      #1;
      rst = 1'b1;
      exp_q = RV; exp_valid = 1'b0; exp_lp = 1'b0;
      #1;
      total++;
      if (q !== RV || q_valid !== 1'b0 || load_p !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid q=%h v=%b lp=%b want q=%h v=0 lp=0", q, q_valid, load_p, RV);
      end
      #1;
      rst = 1'b0; e = 1'b1; d = 4'h7;
      cycle();
      total++;
      if (q !== 4'h7 || q_valid !== 1'b1 || load_p !== 1'b1) begin
         bad++;
         $display("FAIL release_load q=%h v=%b lp=%b want q=7 v=1 lp=1", q, q_valid, load_p);
      end
      e = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         e = ($urandom_range(0, 2) == 0);
         d = (i % 3 == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
         cycle();
         total++;
         if (q !== view() || q_valid !== exp_valid || load_p !== exp_lp) begin
            bad++;
            $display("FAIL random[%0d] q=%h v=%b lp=%b want q=%h v=%b lp=%b",
                     i, q, q_valid, load_p, view(), exp_valid, exp_lp);
         end
      end
      e = 1'b0;
   endtask

`ifdef PIPO_TRANSPARENT_EN
   task automatic test_transparent();
      e = 1'b1; d = 4'h3;
      #1;
      total++;
      if (q !== 4'h3) begin
         bad++;
         $display("FAIL bypass q=%h want 3", q);
      end
      cycle();
      e = 1'b0; d = 4'h9;
      #1;
      total++;
      if (q !== 4'h3) begin
         bad++;
         $display("FAIL bypass_hold q=%h want 3", q);
      end
      cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_hold();
      test_load();
      test_reload();
      test_reset_mid();
      test_random();
`ifdef PIPO_TRANSPARENT_EN
      test_transparent();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
